// File: rtl/peripheral_uart_rx_frame.sv
// ---------------------------------------------------------------------------
// peripheral_uart_rx_frame
//   UART receive framer fed by an already-synchronized RX line. The line is
//   oversampled 16x. The start bit is validated at mid-bit. DATA_W data bits
//   are shifted in LSB first, and the stop bit is checked. Each received byte
//   goes into a one-entry valid/ready holding register.
//
//   Optional feature macro: PERIPHERAL_UART_RX_PARITY_EN
//     defined   : a parity bit follows the data bits and is checked against
//                 XOR(data)^parity_odd. The result is reported on parity_err.
//     undefined : the frame is start + DATA_W + stop, and parity_err is 0.
//
//   Handshake: a byte transfers to the consumer on any rising clk edge where
//   rx_valid and rx_ready are both high. rx_valid stays high, and rx_data,
//   frame_err and parity_err stay stable, until that transfer happens. The
//   holding register can be reloaded in the same cycle as a transfer.
//
//   dbg_state exposes the receive FSM state so that checkers can observe it.
//   The encoding is 0 idle, 1 start, 2 data, 3 parity, 4 stop.
// ---------------------------------------------------------------------------
module peripheral_uart_rx_frame #(
  parameter int DIV_W  = 16,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_sync,
  input  logic              rx_en,
  input  logic [DIV_W-1:0]  baud_div,
  input  logic              parity_odd,
  input  logic              rx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              frame_err,
  output logic              parity_err,
  output logic              overrun,
  output logic              rx_busy,
  output logic [2:0]        dbg_state
);

  localparam int BCW = $clog2(DATA_W);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t            state;
  logic [DIV_W-1:0]  presc;
  logic [DIV_W-1:0]  div_m1;
  logic [3:0]        os_cnt;
  logic [BCW-1:0]    bit_cnt;
  logic [DATA_W-1:0] shreg;
  logic              rx_prev;
  logic              tick;
  logic              sample;

`ifdef PERIPHERAL_UART_RX_PARITY_EN
  logic              par_pend;
`else
  logic              unused_parity_odd;
  assign unused_parity_odd = parity_odd;
  assign parity_err        = 1'b0;
`endif

  // A baud_div of 0 behaves like 1. The '>=' comparison lets a divisor that
  // is lowered mid-count wrap at the next opportunity instead of running
  // round the whole counter.
  assign div_m1 = (baud_div == '0) ? '0 : baud_div - DIV_W'(1);
  assign tick   = (state != S_IDLE) && (presc >= div_m1);
  assign sample = tick && (os_cnt == 4'd7);

  assign rx_busy   = (state != S_IDLE);
  assign dbg_state = state;

  // Receive FSM, oversampling counters, shifter and holding register
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      presc      <= '0;
      os_cnt     <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      rx_prev    <= 1'b0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
`ifdef PERIPHERAL_UART_RX_PARITY_EN
      par_pend   <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      rx_prev <= rx_sync;
      overrun <= 1'b0;

      // The consumer drains the holding register. A commit later in this
      // block overrides this.
      if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end

      if (state != S_IDLE) begin
        if (tick) begin
          presc  <= '0;
          os_cnt <= os_cnt + 4'd1;
        end else begin
          presc  <= presc + DIV_W'(1);
        end
      end

      if (!rx_en) begin
        // Disabling the receiver abandons any partial frame.
        state  <= S_IDLE;
        presc  <= '0;
        os_cnt <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            // A start is a falling edge. rx_prev resets to 0, so a line that
            // is held low through reset does not count as a start.
            if (rx_prev && !rx_sync) begin
              state   <= S_START;
              presc   <= '0;
              os_cnt  <= '0;
              bit_cnt <= '0;
`ifdef PERIPHERAL_UART_RX_PARITY_EN
              par_pend <= 1'b0;
`endif
            end
          end
          S_START: begin
            if (sample) begin
              // If the line is high again at mid-bit, this was a glitch.
              state <= rx_sync ? S_IDLE : S_DATA;
            end
          end
          S_DATA: begin
            if (sample) begin
              shreg   <= {rx_sync, shreg[DATA_W-1:1]};
              bit_cnt <= bit_cnt + BCW'(1);
              if (bit_cnt == BCW'(DATA_W - 1)) begin
`ifdef PERIPHERAL_UART_RX_PARITY_EN
                state <= S_PARITY;
`else
                state <= S_STOP;
`endif
              end
            end
          end
`ifdef PERIPHERAL_UART_RX_PARITY_EN
          S_PARITY: begin
            if (sample) begin
              par_pend <= (rx_sync != (^shreg ^ parity_odd));
              state    <= S_STOP;
            end
          end
`endif
          S_STOP: begin
            if (sample) begin
              state <= S_IDLE;
              // A byte is committed even when its stop bit is bad. It is
              // dropped only if the previous byte is still unconsumed.
              if (!rx_valid || rx_ready) begin
                rx_data   <= shreg;
                frame_err <= ~rx_sync;
                rx_valid  <= 1'b1;
`ifdef PERIPHERAL_UART_RX_PARITY_EN
                parity_err <= par_pend;
`endif
              end else begin
                overrun <= 1'b1;
              end
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_peripheral_uart_rx_frame.sv
// ---------------------------------------------------------------------------
// tb_peripheral_uart_rx_frame
//   Directed bench for the UART receive framer. The bench bit-bangs whole
//   frames on rx_sync. For every complete frame it sent, it schedules the
//   expected commit at the edge given by the latency formula
//   t0 + (8 + 16*stop_index)*div. A transaction-level holding-register model
//   then predicts rx_valid, rx_data, frame_err, parity_err and overrun on
//   every cycle. Hand-written literals pin the byte stream the consumer must
//   accept, the latency and the rx_busy timing.
//   Build with +define+PERIPHERAL_UART_RX_PARITY_EN to exercise parity.
// ---------------------------------------------------------------------------
module tb_peripheral_uart_rx_frame;

  localparam int DATA_W = 8;
  localparam int DIV_W  = 16;
`ifdef PERIPHERAL_UART_RX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic              rx_sync    = 1'b1;
  logic              rx_en      = 1'b1;
  logic [DIV_W-1:0]  baud_div   = 16'd4;
  logic              parity_odd = 1'b0;
  logic              rx_ready   = 1'b1;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid, frame_err, parity_err, overrun, rx_busy;
  logic [2:0]        dbg_state;

  peripheral_uart_rx_frame #(.DIV_W(DIV_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .rx_sync(rx_sync), .rx_en(rx_en),
    .baud_div(baud_div), .parity_odd(parity_odd), .rx_ready(rx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .frame_err(frame_err),
    .parity_err(parity_err), .overrun(overrun), .rx_busy(rx_busy),
    .dbg_state(dbg_state)
  );

  int div = 4;
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  typedef struct {
    int                edge_no;
    logic [DATA_W-1:0] data;
    logic              ferr;
    logic              perr;
  } commit_t;

  commit_t           commit_q[$];
  int                edge_n  = 0;
  logic              m_valid = 1'b0;
  logic [DATA_W-1:0] m_data  = '0;
  logic              m_ferr  = 1'b0;
  logic              m_perr  = 1'b0;
  logic              m_ovr   = 1'b0;

  // Holding-register behaviour at each clock edge, driven by the commit schedule
  always @(posedge clk) begin
    edge_n <= edge_n + 1;
    m_ovr  <= 1'b0;
    if (rst) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_ferr  <= 1'b0;
      m_perr  <= 1'b0;
      commit_q.delete();
    end else if (commit_q.size() != 0 && commit_q[0].edge_no == edge_n + 1) begin
      if (!m_valid || rx_ready) begin
        m_valid <= 1'b1;
        m_data  <= commit_q[0].data;
        m_ferr  <= commit_q[0].ferr;
        m_perr  <= commit_q[0].perr;
      end else begin
        m_ovr <= 1'b1;
      end
      commit_q.delete(0);
    end else if (m_valid && rx_ready) begin
      m_valid <= 1'b0;
    end
  end

  // ---------------- scoreboard ----------------
  logic [DATA_W+1:0] exp_q[$];   // {parity_err, frame_err, data} the consumer must accept
  logic              rv_d      = 1'b0;
  int                last_rise = 0;
  int                ovr_cnt   = 0;

  // Compare the DUT against the model on every cycle, away from the active edge
  always @(negedge clk) begin
    check("rx_valid", rx_valid, m_valid);
    check("overrun", overrun, m_ovr);
    if (m_valid) begin
      check("rx_data", rx_data, m_data);
      check("frame_err", frame_err, m_ferr);
      check("parity_err", parity_err, m_perr);
    end
    if (rx_valid && rx_ready) begin
      check("accept_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        check("accept_byte", {parity_err, frame_err, rx_data}, exp_q[0]);
        exp_q.delete(0);
      end
    end
    rv_d <= rx_valid;
    if (rx_valid && !rv_d) last_rise <= edge_n;
    if (overrun) ovr_cnt <= ovr_cnt + 1;
  end

  // ---------------- driver tasks ----------------
  task automatic wait_edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic b);
    rx_sync = b;
    wait_edges(16 * div);
  endtask

  // Send one full frame. The stop bit can be forced to 0. 'flip' inverts the
  // parity bit when parity is enabled. t0 is the edge that sees the start.
  task automatic send_frame(input logic [DATA_W-1:0] d, input logic stop_b,
                            input logic flip, output int t0);
    commit_t ev;
    t0 = edge_n + 1;
    ev.edge_no = t0 + (8 + 16 * (DATA_W + 1 + PAR)) * div;
    ev.data    = d;
    ev.ferr    = ~stop_b;
    ev.perr    = (PAR != 0) && flip;
    commit_q.push_back(ev);
    drive_bit(1'b0);
    for (int i = 0; i < DATA_W; i++) drive_bit(d[i]);
`ifdef PERIPHERAL_UART_RX_PARITY_EN
    drive_bit(^d ^ parity_odd ^ flip);
`endif
    drive_bit(stop_b);
    rx_sync = 1'b1;
    wait_edges(16 * div);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int t0;
    wait_edges(3);
    rst = 1'b0;
    check("reset_rx_valid", rx_valid, 0);
    check("reset_rx_data", rx_data, 0);
    check("reset_frame_err", frame_err, 0);
    check("reset_parity_err", parity_err, 0);
    check("reset_overrun", overrun, 0);
    check("reset_rx_busy", rx_busy, 0);
    wait_edges(4);

    // 0xA5 8N1, consumer always ready, latency pinned
    exp_q.push_back({2'b00, 8'hA5});
    send_frame(8'hA5, 1'b1, 1'b0, t0);
    check("latency_a5", last_rise - t0, (PAR != 0) ? 672 : 608);

    // glitch: 20 clocks low, rejected at the mid-bit sample (t0+32)
    t0 = edge_n + 1;
    rx_sync = 1'b0;
    wait_edges(20);
    rx_sync = 1'b1;
    wait_edges(t0 + 31 - edge_n);
    check("glitch_busy_before", rx_busy, 1);
    wait_edges(1);
    check("glitch_busy_after", rx_busy, 0);
    wait_edges(64);

    // framing error byte still delivered, next good byte clean
    exp_q.push_back({2'b01, 8'h3C});
    send_frame(8'h3C, 1'b0, 1'b0, t0);
    exp_q.push_back({2'b00, 8'h55});
    send_frame(8'h55, 1'b1, 1'b0, t0);

    // overrun: first byte held, second dropped with a single pulse
    rx_ready = 1'b0;
    ovr_cnt  = 0;
    exp_q.push_back({2'b00, 8'h11});
    send_frame(8'h11, 1'b1, 1'b0, t0);
    send_frame(8'h22, 1'b1, 1'b0, t0);
    check("overrun_pulses", ovr_cnt, 1);
    check("held_byte", rx_data, 8'h11);
    rx_ready = 1'b1;
    wait_edges(4);
    check("drained", exp_q.size(), 0);

`ifdef PERIPHERAL_UART_RX_PARITY_EN
    // odd parity on 0x07 (three ones): parity bit 0 is correct, 1 is wrong
    parity_odd = 1'b1;
    exp_q.push_back({2'b00, 8'h07});
    send_frame(8'h07, 1'b1, 1'b0, t0);
    exp_q.push_back({2'b10, 8'h07});
    send_frame(8'h07, 1'b1, 1'b1, t0);
    parity_odd = 1'b0;
`endif

    // receiver disable mid-frame discards the partial frame
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    check("en_busy_mid", rx_busy, 1);
    rx_en   = 1'b0;
    rx_sync = 1'b1;
    wait_edges(2);
    check("en_busy_off", rx_busy, 0);
    rx_en = 1'b1;
    wait_edges(16 * div * 12);

    // reset mid-frame clears a held byte; a line held low through reset is not a start
    rx_ready = 1'b0;
    send_frame(8'h66, 1'b1, 1'b0, t0);
    check("held_66", rx_valid, 1);
    drive_bit(1'b0);
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    rx_sync = 1'b0;
    rst     = 1'b1;
    wait_edges(3);
    rst = 1'b0;
    wait_edges(10);
    check("rst_valid_cleared", rx_valid, 0);
    check("rst_data_cleared", rx_data, 0);
    check("rst_low_no_start", rx_busy, 0);
    rx_sync = 1'b1;
    wait_edges(16 * div);
    rx_ready = 1'b1;
    exp_q.push_back({2'b00, 8'h81});
    send_frame(8'h81, 1'b1, 1'b0, t0);
    wait_edges(4);
    check("final_drained", exp_q.size(), 0);
    check("final_idle", rx_busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
